ex_stage: RTL
=============

# ex_stage

Execute stage of the five-stage MIPS pipeline, placed directly after the ID/EX register and feeding the data-memory stage. It decodes ALU control from `aluop` and the funct field, and selects the second operand and the destination register. It computes the ALU result, the zero flag and the branch target, then registers everything into an internal EX/MEM register. Most operations take one cycle. MULT runs on an iterative 32-step shift-add unit that back-pressures upstream through `busy`.

## Interface
Parameters:
- `DATA_W`, 32, datapath width; only 32 is supported.
- `MUL_STEPS`, 32, number of multiply iterations; must equal `DATA_W`.

Ports:
- `clk`, input, 1, rising-edge clock.
- `rst_n`, input, 1, asynchronous active-low reset.
- `ctlwb_in`, input, 2, WB control from ID/EX.
- `ctlm_in`, input, 3, MEM control from ID/EX; bit 2 = branch.
- `regdst`, `alusrc`, input, 1 each, EX control.
- `aluop`, input, 2, ALU operation class.
- `npc`, `rdata1`, `rdata2`, `s_extend`, input, 32 each, operands from ID/EX.
- `instr_2016`, `instr_1511`, input, 5 each, candidate destination registers.
- `in_valid`, input, 1, ID/EX holds a real instruction; low means bubble.
- `flush`, input, 1, squash the EX/MEM contents and any multiply in flight.
- `hold`, input, 1, downstream stall; EX/MEM must not change.
- `busy`, output, 1, upstream must freeze ID/EX.
- `wb_ctlout`, output, 2, registered WB control.
- `m_ctlout`, output, 3, registered MEM control.
- `add_result`, output, 32, registered branch target.
- `zero`, output, 1, registered flag; 1 when `alu_result` equals 0.
- `alu_result`, output, 32, registered ALU result.
- `rdata2out`, output, 32, registered store data (raw `rdata2`).
- `muxout`, output, 5, registered destination register.
- `out_valid`, output, 1, EX/MEM holds a real instruction.

## Operation
- Operand B is `s_extend` when `alusrc`=1, otherwise `rdata2`.
- `muxout` is `instr_1511` when `regdst`=1, otherwise `instr_2016`.
- `add_result` = `npc + (s_extend << 2)`, taken modulo 2^32.
- `aluop` decode:
  - 00 = ADD.
  - 01 = SUB.
  - 11 = OR.
  - 10 = decode by funct `s_extend[5:0]`:
    - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR.
    - 0x2A SLT: signed compare; result is 1 or 0.
    - 0x18 MULT: low 32 bits of the unsigned product.
    - Any other funct gives result 0.
- ADD and SUB wrap; there is no overflow trap.
- FSM states: IDLE and MUL.
  - IDLE: when `hold`=0, an edge loads EX/MEM from the current inputs. A bubble (`in_valid`=0) loads all outputs as 0.
  - IDLE -> MUL: a valid MULT in IDLE with `hold`=0 latches A, B and the control fields; EX/MEM is not loaded yet.
  - MUL: one shift-add step per edge. `step_cnt` counts 0..31 and saturates at 32.
  - MUL -> IDLE: at `step_cnt`=32 with `hold`=0, the edge loads EX/MEM with the product and returns to IDLE. With `hold`=1 the FSM waits in MUL.
- `busy` = (state==MUL) | `hold`. The block ignores its inputs while `busy`=1.
- Flush has priority over hold and over MUL: the next edge clears every output to 0, sets state to IDLE and resets `step_cnt`.
- `hold` with `flush`=0: EX/MEM keeps its value; a multiply in progress keeps stepping.

## Timing
- Reset (`rst_n`=0) takes effect immediately, regardless of `clk`:
  - all outputs 0 (`zero` is also 0; it reflects only loaded results);
  - state IDLE, `step_cnt` 0, `busy` 0.
- Single-cycle operations: inputs sampled at edge N; outputs valid after edge N.
- MULT:
  - accepted at edge N; `busy` goes high after edge N;
  - steps run at edges N+1..N+32; result and `out_valid` appear after edge N+32 when `hold`=0;
  - `busy` falls after edge N+32, and the next instruction is sampled at edge N+33.
- Reset deasserted mid-multiply restarts cleanly in IDLE; no partial result is ever presented.

## Test plan
- Reset: pulse `rst_n` low asynchronously between clock edges -> all outputs 0 immediately; the first edge after release with `in_valid`=0 keeps them 0.
- R-type ADD, SUB and SLT: `aluop`=10, `regdst`=1, `rdata1`=5.
  - ADD with `rdata2`=7 -> `alu_result`=12, `muxout`=`instr_1511`.
  - SUB with 5,5 -> result 0, `zero`=1.
  - SLT with 0xFFFFFFFF vs 1 -> result 1.
- Branch: `npc`=0x100, `s_extend`=0xFFFFFFFE, `aluop`=01, equal operands -> `add_result`=0xF8, `zero`=1, `m_ctlout` passed through.
- MULT: 0x0001_0003 × 0x0000_0010 -> `busy` high for 32 cycles; after edge N+32, `alu_result`=0x0010_0030 and `out_valid`=1.
- Flush at step 10 of a MULT -> next edge returns all outputs 0, `busy`=0, state IDLE; the following ADD completes normally.
- Hold: assert `hold` with ADD loaded, present new inputs -> outputs unchanged while held. Release -> new result one edge later. `hold` together with `flush` -> flush wins.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with ALU decode, branch-target adder, iterative
// shift-add multiplier and the EX/MEM pipeline register.
`default_nettype none

module ex_stage #(
  parameter int DATA_W    = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        ctlwb_in,
  input  logic [2:0]        ctlm_in,
  input  logic              regdst,
  input  logic              alusrc,
  input  logic [1:0]        aluop,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [DATA_W-1:0] s_extend,
  input  logic [4:0]        instr_2016,
  input  logic [4:0]        instr_1511,
  input  logic              in_valid,
  input  logic              flush,
  input  logic              hold,
  output logic              busy,
  output logic [1:0]        wb_ctlout,
  output logic [2:0]        m_ctlout,
  output logic [DATA_W-1:0] add_result,
  output logic              zero,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] rdata2out,
  output logic [4:0]        muxout,
  output logic              out_valid
);

  localparam int c_cnt_w = $clog2(MUL_STEPS + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(MUL_STEPS - 1);
  localparam logic [c_cnt_w-1:0] c_done = c_cnt_w'(MUL_STEPS);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  localparam logic [5:0] c_fn_add  = 6'h20;
  localparam logic [5:0] c_fn_sub  = 6'h22;
  localparam logic [5:0] c_fn_and  = 6'h24;
  localparam logic [5:0] c_fn_or   = 6'h25;
  localparam logic [5:0] c_fn_slt  = 6'h2A;
  localparam logic [5:0] c_fn_mult = 6'h18;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] w_opb;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_btgt;
  logic [4:0]        w_dst;
  logic              w_is_mult;

  logic w_clear;
  logic w_ld_alu;
  logic w_ld_mul;
  logic w_start;

  logic [DATA_W-1:0]  r_ma;
  logic [DATA_W-1:0]  r_mb;
  logic [DATA_W-1:0]  r_acc;
  logic [c_cnt_w-1:0] r_step_cnt;
  logic [DATA_W-1:0]  w_acc_nxt;
  logic [DATA_W-1:0]  w_prod;

  logic [1:0]        r_p_wb;
  logic [2:0]        r_p_m;
  logic [DATA_W-1:0] r_p_add;
  logic [DATA_W-1:0] r_p_rd2;
  logic [4:0]        r_p_dst;

  logic [1:0]        r_wb;
  logic [2:0]        r_m;
  logic [DATA_W-1:0] r_add;
  logic              r_zero;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_rd2;
  logic [4:0]        r_dst;
  logic              r_valid;

  // Operand select, destination select, branch target and ALU decode
  always_comb begin
    w_opb     = alusrc ? s_extend : rdata2;
    w_dst     = regdst ? instr_1511 : instr_2016;
    w_btgt    = npc + {s_extend[DATA_W-3:0], 2'b00};
    w_is_mult = 1'b0;
    w_alu     = '0;
    case (aluop)
      2'b00: w_alu = rdata1 + w_opb;
      2'b01: w_alu = rdata1 - w_opb;
      2'b11: w_alu = rdata1 | w_opb;
      default: begin
        case (s_extend[5:0])
          c_fn_add:  w_alu = rdata1 + w_opb;
          c_fn_sub:  w_alu = rdata1 - w_opb;
          c_fn_and:  w_alu = rdata1 & w_opb;
          c_fn_or:   w_alu = rdata1 | w_opb;
          c_fn_slt:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(rdata1) < $signed(w_opb))};
          c_fn_mult: w_is_mult = 1'b1;
          default:   w_alu = '0;
        endcase
      end
    endcase
  end

  always_comb begin
    w_acc_nxt = r_acc + (r_mb[0] ? r_ma : '0);
    // The final step and the EX/MEM load share one edge unless hold stretched it.
    w_prod    = (r_step_cnt == c_done) ? r_acc : w_acc_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_ld_alu    = 1'b0;
    w_ld_mul    = 1'b0;
    w_start     = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_clear     = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!hold) begin
            if (in_valid && w_is_mult) begin
              w_start     = 1'b1;
              w_state_nxt = S_MUL;
            end else begin
              w_ld_alu = 1'b1;
            end
          end
        end
        S_MUL: begin
          if (!hold && (r_step_cnt >= c_last)) begin
            w_ld_mul    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_MUL) | hold;

  // Shift-add multiplier; A shifts left, B shifts right, one partial product per edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ma       <= '0;
      r_mb       <= '0;
      r_acc      <= '0;
      r_step_cnt <= '0;
      r_p_wb     <= '0;
      r_p_m      <= '0;
      r_p_add    <= '0;
      r_p_rd2    <= '0;
      r_p_dst    <= '0;
    end else if (w_clear) begin
      r_step_cnt <= '0;
    end else if (w_start) begin
      r_ma       <= rdata1;
      r_mb       <= w_opb;
      r_acc      <= '0;
      r_step_cnt <= '0;
      r_p_wb     <= ctlwb_in;
      r_p_m      <= ctlm_in;
      r_p_add    <= w_btgt;
      r_p_rd2    <= rdata2;
      r_p_dst    <= w_dst;
    end else if (r_state == S_MUL) begin
      if (r_step_cnt != c_done) begin
        r_acc      <= w_acc_nxt;
        r_ma       <= r_ma << 1;
        r_mb       <= r_mb >> 1;
        r_step_cnt <= r_step_cnt + c_one;
      end
      if (w_ld_mul) begin
        r_step_cnt <= '0;
      end
    end
  end

  // EX/MEM register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb    <= '0;
      r_m     <= '0;
      r_add   <= '0;
      r_zero  <= 1'b0;
      r_alu   <= '0;
      r_rd2   <= '0;
      r_dst   <= '0;
      r_valid <= 1'b0;
    end else if (w_clear || (w_ld_alu && !in_valid)) begin
      r_wb    <= '0;
      r_m     <= '0;
      r_add   <= '0;
      r_zero  <= 1'b0;
      r_alu   <= '0;
      r_rd2   <= '0;
      r_dst   <= '0;
      r_valid <= 1'b0;
    end else if (w_ld_alu) begin
      r_wb    <= ctlwb_in;
      r_m     <= ctlm_in;
      r_add   <= w_btgt;
      r_zero  <= (w_alu == '0);
      r_alu   <= w_alu;
      r_rd2   <= rdata2;
      r_dst   <= w_dst;
      r_valid <= 1'b1;
    end else if (w_ld_mul) begin
      r_wb    <= r_p_wb;
      r_m     <= r_p_m;
      r_add   <= r_p_add;
      r_zero  <= (w_prod == '0);
      r_alu   <= w_prod;
      r_rd2   <= r_p_rd2;
      r_dst   <= r_p_dst;
      r_valid <= 1'b1;
    end
  end

  assign wb_ctlout  = r_wb;
  assign m_ctlout   = r_m;
  assign add_result = r_add;
  assign zero       = r_zero;
  assign alu_result = r_alu;
  assign rdata2out  = r_rd2;
  assign muxout     = r_dst;
  assign out_valid  = r_valid;

endmodule

`default_nettype wire
